// File: rtl/axi_slave_mem.sv
// Single-port-per-direction AXI3-style slave backed by a byte-lane-writable word memory.
// Independent write and read FSMs, one burst in flight per direction, SLVERR on bad beats.
module axi_slave_mem #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  awid,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [31:0] awaddr,
    input  logic [1:0]  awburst,
    input  logic        wvalid,
    output logic        wready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        bready,
    output logic        bvalid,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [3:0]  arid,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [31:0] araddr,
    input  logic [1:0]  arburst,
    input  logic        rready,
    output logic        rvalid,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic [1:0]  rresp
);
    localparam int unsigned IW        = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    // WRAP uses a mask; non-power-of-two containers only occur for illegal lens, whose beats all error anyway.
    function automatic logic [31:0] f_next_addr(input logic [31:0] addr, input logic [3:0] len,
                                                input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] incr;
        logic [31:0] mask;
        incr = 32'd1 << size;
        mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            2'b00:   f_next_addr = addr;
            2'b10:   f_next_addr = (addr & ~mask) | ((addr + incr) & mask);
            default: f_next_addr = addr + incr;
        endcase
    endfunction

    function automatic logic f_beat_err(input logic [31:0] addr, input logic [3:0] len,
                                        input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] off;
        logic        err;
        off = addr - BASE_ADDR;
        err = (off >= MEM_BYTES) || (size > 3'd2) || (burst == 2'b11);
        if (burst == 2'b10) begin
            if (!(len inside {4'd1, 4'd3, 4'd7, 4'd15})) err = 1'b1;
            if ((addr & ((32'd1 << size) - 32'd1)) != 32'd0) err = 1'b1;
        end
        f_beat_err = err;
    endfunction

    logic [31:0] r_mem [MEM_WORDS];

    wstate_t     r_wstate, w_wstate_nxt;
    logic [3:0]  r_awid, r_awlen, r_wcnt;
    logic [2:0]  r_awsize;
    logic [1:0]  r_awburst;
    logic [31:0] r_waddr;
    logic        r_werr;

    rstate_t     r_rstate, w_rstate_nxt;
    logic [3:0]  r_arid, r_arlen, r_rcnt;
    logic [2:0]  r_arsize;
    logic [1:0]  r_arburst;
    logic [31:0] r_raddr;

    logic [31:0] w_woff, w_roff;
    logic [IW-1:0] w_widx, w_ridx;
    logic        w_wbeat_err, w_rbeat_err, w_wlast_beat, w_rlast_beat, w_w_hs;
    logic        w_unused;

    assign w_woff       = r_waddr - BASE_ADDR;
    assign w_roff       = r_raddr - BASE_ADDR;
    assign w_widx       = w_woff[IW+1:2];
    assign w_ridx       = w_roff[IW+1:2];
    assign w_wbeat_err  = f_beat_err(r_waddr, r_awlen, r_awsize, r_awburst);
    assign w_rbeat_err  = f_beat_err(r_raddr, r_arlen, r_arsize, r_arburst);
    assign w_wlast_beat = (r_wcnt == r_awlen);
    assign w_rlast_beat = (r_rcnt == r_arlen);
    assign w_w_hs       = wvalid & wready;
    assign w_unused     = ^{wid, w_woff[1:0], w_woff[31:IW+2], w_roff[1:0], w_roff[31:IW+2]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        awready      = 1'b0;
        wready       = 1'b0;
        bvalid       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                awready = resetn;
                if (awvalid && resetn) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_wlast_beat) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    assign bid   = bvalid ? r_awid : 4'd0;
    assign bresp = (bvalid && r_werr) ? 2'b10 : 2'b00;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_awid    <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
            r_waddr   <= '0;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
        end else if (awvalid && awready) begin
            r_awid    <= awid;
            r_awlen   <= awlen;
            r_awsize  <= awsize;
            r_awburst <= awburst;
            r_waddr   <= awaddr;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
        end else if (w_w_hs) begin
            r_waddr <= f_next_addr(r_waddr, r_awlen, r_awsize, r_awburst);
            r_wcnt  <= r_wcnt + 4'd1;
            if (w_wbeat_err || (wlast != w_wlast_beat)) r_werr <= 1'b1;
        end
    end

    // Memory is deliberately not reset so contents survive an aborted burst.
    always_ff @(posedge clk) begin
        if (w_w_hs && !w_wbeat_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) r_mem[w_widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        arready      = 1'b0;
        rvalid       = 1'b0;
        if (r_rstate == R_IDLE) begin
            arready = resetn;
            if (arvalid && resetn) w_rstate_nxt = R_DATA;
        end else begin
            rvalid = 1'b1;
            if (rready && w_rlast_beat) w_rstate_nxt = R_IDLE;
        end
    end

    assign rid   = rvalid ? r_arid : 4'd0;
    assign rlast = rvalid && w_rlast_beat;
    assign rresp = (rvalid && w_rbeat_err) ? 2'b10 : 2'b00;
    assign rdata = (rvalid && !w_rbeat_err) ? r_mem[w_ridx] : 32'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_arid    <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_raddr   <= '0;
            r_rcnt    <= '0;
        end else if (arvalid && arready) begin
            r_arid    <= arid;
            r_arlen   <= arlen;
            r_arsize  <= arsize;
            r_arburst <= arburst;
            r_raddr   <= araddr;
            r_rcnt    <= '0;
        end else if (rvalid && rready) begin
            r_raddr <= f_next_addr(r_raddr, r_arlen, r_arsize, r_arburst);
            r_rcnt  <= r_rcnt + 4'd1;
        end
    end
endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 Parameter MEM_WORDS, default 256: number of 32-bit memory words; power of two, 16..4096.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; aligned to MEM_WORDS*4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 AW inputs: awvalid 1, awid 4, awlen 4, awsize 3, awaddr 32, awburst 2; output: awready 1.
REQ-006 W inputs: wvalid 1, wid 4, wdata 32, wstrb 4, wlast 1; output: wready 1.
REQ-007 B input: bready 1; outputs: bvalid 1, bid 4, bresp 2.
REQ-008 AR inputs: arvalid 1, arid 4, arlen 4, arsize 3, araddr 32, arburst 2; output: arready 1.
REQ-009 R input: rready 1; outputs: rvalid 1, rid 4, rdata 32, rlast 1, rresp 2.

Function
REQ-010 Write and read paths are independent FSMs sharing one byte-lane-writable memory array; each handles one burst at a time, no outstanding-transaction queue.
REQ-011 Write FSM states: W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-012 W_IDLE: on awvalid&awready, latch awid/awaddr/awlen/awsize/awburst, clear beat counter and error flag, go to W_DATA next cycle.
REQ-013 W_DATA: each wvalid&wready beat writes wdata byte lanes with wstrb=1 at current word; lanes with wstrb=0 are unchanged; address advances per REQ-019; beat counter increments.
REQ-014 The beat with counter==latched len ends the burst, goes to W_RESP; wlast is not used to terminate; wlast!=(counter==len) on any beat sets the error flag.
REQ-015 W_RESP: bid=latched awid; bresp=2'b10 (SLVERR) if error flag set, else 2'b00; bvalid held, all fields stable until bready; on bvalid&bready go to W_IDLE.
REQ-016 Read FSM states: R_IDLE, R_DATA; arready=1 only in R_IDLE, rvalid=1 only in R_DATA.
REQ-017 R_IDLE: on arvalid&arready, latch AR fields, clear beat counter, go to R_DATA; first rvalid cycle directly after the handshake (latency 1).
REQ-018 R_DATA: rdata = memory word at current address (combinational read), rid=latched arid, rlast=(counter==latched len); fields stable while rvalid&!rready; on rvalid&rready advance address and counter; handshake with rlast=1 returns to R_IDLE.
REQ-019 Next address: FIXED (2'b00) unchanged; INCR (2'b01) addr+(1<<size), 32-bit wrap-around; WRAP (2'b10) container=(len+1)<<size, addr=container-aligned base+((addr+(1<<size)) mod container); reserved 2'b11 treated as INCR.
REQ-020 Error conditions per beat, any one gives SLVERR: address outside BASE_ADDR..BASE_ADDR+MEM_WORDS*4-1; size>2; burst=2'b11; WRAP with len not in {1,3,7,15}; WRAP with unaligned start address.
REQ-021 Erroring write beat suppresses memory write; erroring read beat returns rdata=0 and rresp=2'b10 for that beat only; otherwise rresp=2'b00.
REQ-022 Word index = (addr-BASE_ADDR)>>2; byte offset bits ignored for narrow sizes (wstrb selects lanes).
REQ-023 wid is ignored.
REQ-024 Write and read to same word in same cycle: read returns pre-write data; write takes effect at the clock edge.
REQ-025 AW and AR handshakes in the same cycle are both accepted.

Reset
REQ-026 resetn low: both FSMs to idle immediately; awready, wready, bvalid, arready, rvalid, rlast = 0; bid, bresp, rid, rresp, rdata = 0; ready outputs gated low while resetn=0.
REQ-027 Reset mid-burst abandons the burst with no response; memory contents are not reset; beats already written persist.
REQ-028 First cycle after release: awready=1, arready=1.

Verification
REQ-029 INCR write awaddr=0x10, awlen=3, awsize=2, wdata=A0..A3, wstrb=4'hF -> bresp=00, bid=awid; INCR read same -> rdata A0..A3, rlast only on beat 4.
REQ-030 WRAP write awaddr=0x38, awlen=3, awsize=2 -> words written at 0x38,0x3C,0x30,0x34; read back matches.
REQ-031 Write 0xFFFF_FFFF then write 0x1234_5678 wstrb=4'b0101 -> read 0xFF34_FF78.
REQ-032 awaddr=BASE_ADDR+MEM_WORDS*4, awlen=0 -> bresp=10, memory unchanged; read same address -> rdata=0, rresp=10, rlast=1.
REQ-033 awlen=2 with wlast on beat 2 -> 3 beats accepted, bresp=10; rready/bready held low 5 cycles -> rvalid/bvalid and fields stable.
REQ-034 resetn pulsed low during beat 2 of a 4-beat read -> rvalid=0 immediately, arready=1 after release, no further R beats.
